pkt_stream_router: RTL
======================

# pkt_stream_router

Parametrised, packet-atomic AXI-Stream demultiplexer that sits between the command/packet input stream and the per-object game-logic consumers (player, bullet, enemy, …). It decodes a type field on the first beat of each packet and latches that decision until `tlast`, so every beat of a multi-beat packet reaches the same port. Output is registered with a one-beat pipeline stage. Packets with unmapped types are consumed in full and counted.

## Interface
Parameters:
- `DATA_W`, 64: stream data width.
- `NUM_PORTS`, 4: output port count, 1–16.
- `TYPE_LSB`, 0: bit position of the type field in the header beat.
- `TYPE_W`, 8: type field width.
- `TYPE_BASE`, 8'h01: type value mapped to port 0; type `TYPE_BASE+k` maps to port k for k < NUM_PORTS.

Ports:
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_s_axis_tdata` in DATA_W: input data.
- `i_s_axis_tvalid` in 1: input valid.
- `i_s_axis_tlast` in 1: last beat of packet.
- `o_s_axis_tready` out 1: input ready.
- `o_m_axis_tdata` out NUM_PORTS*DATA_W: per-port data, port k at bits [k*DATA_W +: DATA_W].
- `o_m_axis_tvalid` out NUM_PORTS: per-port valid.
- `o_m_axis_tlast` out NUM_PORTS: per-port last.
- `i_m_axis_tready` in NUM_PORTS: per-port ready.
- `o_drop_count` out 16: dropped-packet count, saturating.
- `o_busy` out 1: high while mid-packet (state FWD or DROP).

## Operation
- FSM states: IDLE, FWD, DROP.
  - **IDLE:** the input beat is the header. Type = `tdata[TYPE_LSB +: TYPE_W]`.
    - Mapped type: latch port index `sel`. Accept the beat into the output stage. Go to FWD, or stay in IDLE if `tlast`.
    - Unmapped type: accept the beat (`o_s_axis_tready`=1) and discard it. Increment `o_drop_count`. Go to DROP, or stay in IDLE if `tlast`.
  - **FWD:** every beat goes to `sel` regardless of its own type bits. The accept with `tlast` returns to IDLE.
  - **DROP:** `o_s_axis_tready`=1. Beats are discarded. The accept with `tlast` returns to IDLE. No further count increments.
- Output stage: one shared register holding `{data, last, valid}` plus `out_sel`. Only `o_m_axis_tvalid[out_sel]` can be high; all other valids are 0. Data and last are driven to all ports, and only the selected port's valid qualifies them.
- Ready rule (forwarding path): `o_s_axis_tready = !out_valid || i_m_axis_tready[out_sel]`. The stage loads on accept and clears when the selected port takes the beat and no new beat is accepted. In a given cycle, the incoming beat's target port may differ from `out_sel` only at a packet boundary. The load still follows the ready rule above.
- Held beat: while `out_valid && !i_m_axis_tready[out_sel]`, data, last and sel are held stable.
- Arithmetic: port index = type − TYPE_BASE, computed at TYPE_W+1 bits. The type is mapped iff there is no borrow and index < NUM_PORTS.
- Counter: `o_drop_count` stops at 16'hFFFF and does not wrap.
- Reset (asynchronous, any time, including mid-packet):
  - FSM returns to IDLE and `out_valid` goes to 0.
  - All `o_m_axis_tvalid`, `o_m_axis_tlast` and `o_m_axis_tdata` outputs are 0.
  - `o_drop_count`=0, `o_busy`=0.
  - The partial packet is lost. The next beat after reset is treated as a header.

## Timing
- Latency: an input beat accepted at edge N appears on the output at edge N; it is visible as valid from cycle N+1.
- Throughput: one beat per cycle sustained while the selected port holds ready high.
- Ready path: `o_s_axis_tready` depends combinationally on `i_m_axis_tready` and on registered state only. It does not depend on `i_s_axis_tvalid`.
- `o_drop_count` updates on the edge that accepts the unmapped header.
- `o_busy` is registered and reflects the FSM state.

## Test plan
- **Single-beat routing:** send headers of type 01, 02, 03, 04 with tlast=1 and all readies high. Each beat appears on ports 0–3 respectively, one cycle later, with tlast=1. `o_drop_count` stays 0.
- **Packet atomicity:** send a 3-beat packet with header type 03, then beats whose byte 0 is 01 and 02. All 3 beats go to port 2 with tlast on beat 3 only. Port 0 and port 1 valids never assert.
- **Backpressure:** port 1 ready is held low for 5 cycles during a 4-beat type-02 packet.
  - The output stays stable, `o_s_axis_tready`=0 while the stage is full, and no beat is lost or duplicated.
  - After ready rises, beats arrive in order at 1 per cycle.
- **Drop:** send a 3-beat packet of type 7F, then a type-01 packet.
  - Drop case: tready=1 on all 3 beats, no port valid, `o_drop_count`=1.
  - The type-01 packet then routes to port 0.
  - Force the counter to 16'hFFFF; one further drop leaves it at 16'hFFFF.
- **Type 00 (below base):** the packet is dropped. This confirms there is no underflow aliasing to port 255.
- **Reset mid-packet:** assert `i_rst_n` low during beat 2 of a type-02 packet.
  - All valids, `o_busy` and `o_drop_count` go to 0 immediately.
  - After release, the next beat (type 04) routes to port 3 as a header.

Source files
------------

// File: rtl/pkt_stream_router_if.sv
// Stream bundle between the packet source, the router and its per-port consumers.
// Latency: none, wires only.
// Backpressure: carries tready in both directions, input stream and per-port outputs.
interface pkt_stream_router_if #(
    parameter int DATA_W    = 64,
    parameter int NUM_PORTS = 4
);
    logic [DATA_W-1:0]           i_s_axis_tdata;
    logic                        i_s_axis_tvalid;
    logic                        i_s_axis_tlast;
    logic                        o_s_axis_tready;
    logic [NUM_PORTS*DATA_W-1:0] o_m_axis_tdata;
    logic [NUM_PORTS-1:0]        o_m_axis_tvalid;
    logic [NUM_PORTS-1:0]        o_m_axis_tlast;
    logic [NUM_PORTS-1:0]        i_m_axis_tready;
    logic [15:0]                 o_drop_count;
    logic                        o_busy;

    // Router side: consumes the input stream and drives the output ports.
    modport slave (
        input  i_s_axis_tdata, i_s_axis_tvalid, i_s_axis_tlast,
        output o_s_axis_tready,
        output o_m_axis_tdata, o_m_axis_tvalid, o_m_axis_tlast,
        input  i_m_axis_tready,
        output o_drop_count, o_busy
    );

    // Environment side: produces the input stream and sinks the output ports.
    modport master (
        output i_s_axis_tdata, i_s_axis_tvalid, i_s_axis_tlast,
        input  o_s_axis_tready,
        input  o_m_axis_tdata, o_m_axis_tvalid, o_m_axis_tlast,
        output i_m_axis_tready,
        input  o_drop_count, o_busy
    );
endinterface

// File: rtl/pkt_stream_router.sv
// Packet-atomic stream demux: header type picks an output port, held until tlast; unmapped packets dropped and counted.
// Latency: one registered stage, beat accepted at edge N is valid on its port from cycle N+1.
// Backpressure: input ready = stage empty or selected port ready (always ready while dropping); held beat stays stable.
module pkt_stream_router #(
    parameter int              DATA_W    = 64,
    parameter int              NUM_PORTS = 4,
    parameter int              TYPE_LSB  = 0,
    parameter int              TYPE_W    = 8,
    parameter logic [TYPE_W-1:0] TYPE_BASE = 'h01
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    pkt_stream_router_if.slave bus
);

    localparam int                SEL_W  = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam logic [TYPE_W:0]   NP_EXT = (TYPE_W+1)'(NUM_PORTS);

    typedef enum logic [1:0] {ST_IDLE, ST_FWD, ST_DROP} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [SEL_W-1:0]    out_sel_q, out_sel_d;
    logic                out_vld_q, out_vld_d;
    logic [DATA_W-1:0]   out_dat_q, out_dat_d;
    logic                out_last_q, out_last_d;
    logic [15:0]         drop_cnt_q, drop_cnt_d;
    logic                busy_q, busy_d;

    logic [TYPE_W-1:0]   hdr_type;
    logic [TYPE_W:0]     type_diff;
    logic                type_mapped;
    logic [SEL_W-1:0]    hdr_sel;
    logic                out_take;
    logic                s_rdy;
    logic                s_acc;
    logic                fwd_acc;

    // Header decode: one extra bit catches the borrow so types below the base never alias to a high port.
    always_comb begin
        hdr_type    = bus.i_s_axis_tdata[TYPE_LSB +: TYPE_W];
        type_diff   = {1'b0, hdr_type} - {1'b0, TYPE_BASE};
        type_mapped = !type_diff[TYPE_W] && (type_diff < NP_EXT);
        hdr_sel     = type_diff[SEL_W-1:0];
    end

    // Ready depends only on registered state and downstream ready, never on input valid.
    always_comb begin
        out_take = out_vld_q && bus.i_m_axis_tready[out_sel_q];
        s_rdy    = (state_q == ST_DROP) || !out_vld_q || bus.i_m_axis_tready[out_sel_q];
        s_acc    = bus.i_s_axis_tvalid && s_rdy;
    end

    // Packet FSM: decode on the header beat, hold the port (or the drop) until the tlast accept.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        drop_cnt_d = drop_cnt_q;
        fwd_acc    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_acc) begin
                    if (type_mapped) begin
                        sel_d   = hdr_sel;
                        fwd_acc = 1'b1;
                        if (!bus.i_s_axis_tlast) state_d = ST_FWD;
                    end else begin
                        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
                        if (!bus.i_s_axis_tlast) state_d = ST_DROP;
                    end
                end
            end
            ST_FWD: begin
                if (s_acc) begin
                    fwd_acc = 1'b1;
                    if (bus.i_s_axis_tlast) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (s_acc && bus.i_s_axis_tlast) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // Output stage: load on a forwarded accept, otherwise drain when the selected port takes the beat.
    always_comb begin
        out_vld_d  = out_vld_q && !out_take;
        out_dat_d  = out_dat_q;
        out_last_d = out_last_q;
        out_sel_d  = out_sel_q;
        if (fwd_acc) begin
            out_vld_d  = 1'b1;
            out_dat_d  = bus.i_s_axis_tdata;
            out_last_d = bus.i_s_axis_tlast;
            out_sel_d  = sel_d;
        end
    end

    // State and output registers, all cleared by reset so a partial packet is simply abandoned.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            out_sel_q  <= '0;
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            out_last_q <= 1'b0;
            drop_cnt_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            out_sel_q  <= out_sel_d;
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            out_last_q <= out_last_d;
            drop_cnt_q <= drop_cnt_d;
            busy_q     <= busy_d;
        end
    end

    // Data and last fan out to every port; only the selected port's valid qualifies them.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            bus.o_m_axis_tvalid[k] = out_vld_q && (out_sel_q == SEL_W'(k));
        end
    end

    assign bus.o_m_axis_tdata  = {NUM_PORTS{out_dat_q}};
    assign bus.o_m_axis_tlast  = {NUM_PORTS{out_last_q}};
    assign bus.o_s_axis_tready = s_rdy;
    assign bus.o_drop_count    = drop_cnt_q;
    assign bus.o_busy          = busy_q;

endmodule
